// File: rtl/bar_graph_mapper.sv
// Multi-bar spectrum colour mapper with per-bar peak-hold markers.
// Amplitudes are double-buffered and swapped on each frame edge.
module bar_graph_mapper #(
  parameter int NUM_BARS   = 10,
  parameter int BAR_X0     = 10,
  parameter int BAR_W      = 53,
  parameter int BAR_GAP    = 10,
  parameter int SCREEN_H   = 480,
  parameter int PEAK_H     = 3,
  parameter int PEAK_HOLD  = 30,
  parameter int PEAK_DECAY = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       Amp_we,
  input  logic [3:0] Amp_addr,
  input  logic [9:0] Amp_data,
  input  logic       Mode,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue
);

  localparam int HW = $clog2(PEAK_HOLD + 1);
  localparam logic [10:0] L_H  = 11'(SCREEN_H);
  localparam logic [10:0] L_PH = 11'(PEAK_H);
  localparam logic [10:0] L_PD = 11'(PEAK_DECAY);

  logic [9:0]    r_shadow [NUM_BARS];
  logic [9:0]    r_active [NUM_BARS];
  logic [9:0]    r_peak   [NUM_BARS];
  logic [HW-1:0] r_hold   [NUM_BARS];
  logic          r_frame_q;

  logic                w_swap;
  logic [9:0]          w_wdata;
  logic [10:0]         w_x;
  logic [10:0]         w_y;
  logic [9:0]          w_pk_next [NUM_BARS];
  logic [NUM_BARS-1:0] w_bar;
  logic [NUM_BARS-1:0] w_pk;
  logic [7:0]          w_r;
  logic [7:0]          w_g;
  logic [7:0]          w_b;

  assign w_swap  = frame_clk & ~r_frame_q;
  assign w_wdata = ({1'b0, Amp_data} > L_H) ? L_H[9:0] : Amp_data;
  assign w_x     = {1'b0, DrawX};
  assign w_y     = {1'b0, DrawY};

  for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
    localparam logic [10:0] LO = 11'(BAR_X0 + g * (BAR_W + BAR_GAP));
    localparam logic [10:0] HI = 11'(BAR_X0 + g * (BAR_W + BAR_GAP) + BAR_W - 1);
    logic        w_inx;
    logic [10:0] w_top;
    logic [10:0] w_pk_lo;
    logic [10:0] w_dec;

    assign w_inx   = (w_x >= LO) && (w_x <= HI);
    assign w_top   = L_H - {1'b0, r_peak[g]};
    assign w_pk_lo = (w_top >= L_PH) ? w_top - L_PH : '0;
    assign w_bar[g] = w_inx && (w_y < L_H) &&
                      (w_y >= L_H - {1'b0, r_active[g]});
    // w_y < w_top keeps a full-height peak (top=0) from wrapping
    assign w_pk[g] = w_inx && (r_peak[g] != '0) &&
                     (w_y >= w_pk_lo) && (w_y < w_top);
    assign w_dec = ({1'b0, r_peak[g]} >= L_PD) ?
                   {1'b0, r_peak[g]} - L_PD : '0;
    assign w_pk_next[g] = (w_dec > {1'b0, r_shadow[g]}) ?
                          w_dec[9:0] : r_shadow[g];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_frame_q <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
        r_peak[i]   <= '0;
        r_hold[i]   <= '0;
      end
    end else begin
      r_frame_q <= frame_clk;
      for (int i = 0; i < NUM_BARS; i++) begin
        if (w_swap) begin
          r_active[i] <= r_shadow[i];
          if (r_shadow[i] >= r_peak[i]) begin
            r_peak[i] <= r_shadow[i];
            r_hold[i] <= HW'(PEAK_HOLD);
          end else if (r_hold[i] != '0) begin
            r_hold[i] <= r_hold[i] - HW'(1);
          end else begin
            r_peak[i] <= w_pk_next[i];
          end
        end
        if (Amp_we && (Amp_addr == 4'(i)))
          r_shadow[i] <= w_wdata;
      end
    end
  end

  always_comb begin
    w_r = 8'h00;
    w_g = 8'h00;
    w_b = 8'h7F - {1'b0, DrawX[9:3]};
    unique case (1'b1)
      (|w_pk): begin
        w_r = 8'hFF;
        w_g = 8'hFF;
        w_b = 8'hFF;
      end
      (|w_bar): begin
        w_r = 8'hFF;
        w_g = Mode ? DrawY[8:1] : 8'h55;
        w_b = 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else begin
      Red   <= w_r;
      Green <= w_g;
      Blue  <= w_b;
    end
  end

endmodule

// File: tb/tb_bar_graph_mapper.sv
// Bench for bar_graph_mapper: arithmetic model checked every cycle
// plus hand-computed pixel colours at the interesting points.
module tb_bar_graph_mapper;

  localparam int NB = 10;

  logic       Clk = 0;
  logic       Reset_n = 0;
  logic       frame_clk = 0;
  logic       Amp_we = 0;
  logic [3:0] Amp_addr = 0;
  logic [9:0] Amp_data = 0;
  logic       Mode = 0;
  logic [9:0] DrawX = 0;
  logic [9:0] DrawY = 0;
  logic [7:0] Red, Green, Blue;

  int checks = 0;
  int errors = 0;

  bar_graph_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .Amp_we(Amp_we), .Amp_addr(Amp_addr), .Amp_data(Amp_data),
    .Mode(Mode), .DrawX(DrawX), .DrawY(DrawY),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  always #5 Clk = ~Clk;

  int  m_sh [NB];
  int  m_act [NB];
  int  m_pk [NB];
  int  m_hold [NB];
  bit  m_fq;
  bit  exp_valid = 0;
  logic [23:0] exp_rgb;

  function automatic logic [23:0] px(int x, int y, bit m);
    bit pkh, barh;
    int lo, plo;
    pkh = 0;
    barh = 0;
    for (int i = 0; i < NB; i++) begin
      lo = 10 + i * 63;
      if (x >= lo && x <= lo + 52) begin
        plo = 480 - m_pk[i] - 3;
        if (plo < 0) plo = 0;
        if (m_pk[i] > 0 && y >= plo && y <= 480 - m_pk[i] - 1) pkh = 1;
        if (y < 480 && y >= 480 - m_act[i]) barh = 1;
      end
    end
    if (pkh) return 24'hFFFFFF;
    if (barh) return m ? {8'hFF, 8'(y / 2), 8'h00} : 24'hFF5500;
    return {16'h0, 8'(8'h7F - 8'(x / 8))};
  endfunction

  always @(posedge Clk) begin
    int a, d;
    if (!Reset_n) begin
      exp_rgb = 24'h0;
      m_fq = 0;
      for (int i = 0; i < NB; i++) begin
        m_sh[i] = 0; m_act[i] = 0; m_pk[i] = 0; m_hold[i] = 0;
      end
    end else begin
      exp_rgb = px(int'(DrawX), int'(DrawY), Mode);
      if (frame_clk && !m_fq) begin
        for (int i = 0; i < NB; i++) begin
          a = m_sh[i];
          m_act[i] = a;
          if (a >= m_pk[i]) begin
            m_pk[i] = a; m_hold[i] = 30;
          end else if (m_hold[i] > 0) begin
            m_hold[i] = m_hold[i] - 1;
          end else begin
            d = m_pk[i] - 2;
            if (d < 0) d = 0;
            m_pk[i] = (d > a) ? d : a;
          end
        end
      end
      m_fq = frame_clk;
      if (Amp_we && int'(Amp_addr) < NB)
        m_sh[Amp_addr] = (int'(Amp_data) > 480) ? 480 : int'(Amp_data);
    end
    exp_valid = 1;
  end

  always @(negedge Clk) begin
    if (exp_valid) begin
      checks++;
      if ({Red, Green, Blue} !== exp_rgb) begin
        errors++;
        $display("FAIL model x=%0d y=%0d got %h want %h",
                 DrawX, DrawY, {Red, Green, Blue}, exp_rgb);
      end
    end
  end

  task automatic chk(string name, logic [23:0] want);
    checks++;
    if ({Red, Green, Blue} !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, {Red, Green, Blue}, want);
    end
  endtask

  task automatic pix(int x, int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge Clk);
  endtask

  task automatic wr(int addr, int data);
    @(negedge Clk);
    Amp_we = 1; Amp_addr = 4'(addr); Amp_data = 10'(data);
    @(negedge Clk);
    Amp_we = 0;
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_clk = 1;
    @(negedge Clk);
    @(negedge Clk);
    frame_clk = 0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset_n = 1;
    pix(20, 470);   chk("reset_bg", 24'h00007D);

    wr(0, 100); frame();
    pix(10, 380);   chk("bar0_top", 24'hFF5500);
    pix(10, 379);   chk("bar0_peak", 24'hFFFFFF);
    pix(10, 377);   chk("bar0_peak_lo", 24'hFFFFFF);
    pix(10, 376);   chk("bar0_above", 24'h00007E);

    wr(1, 100);
    pix(73, 470);   chk("noswap_dark", 24'h000076);
    frame();
    pix(73, 470);   chk("swap_lit", 24'hFF5500);
    @(negedge Clk);
    frame_clk = 1; Amp_we = 1; Amp_addr = 4'd1; Amp_data = 10'd50;
    @(negedge Clk);
    Amp_we = 0;
    @(negedge Clk);
    frame_clk = 0;
    pix(73, 385);   chk("wr_in_swap_old", 24'hFF5500);
    frame();
    pix(73, 385);   chk("wr_in_swap_new", 24'h000076);
    pix(73, 430);   chk("bar1_50", 24'hFF5500);
    pix(73, 378);   chk("bar1_peak_held", 24'hFFFFFF);

    wr(3, 200); frame();
    wr(3, 0);
    for (int f = 0; f < 30; f++) begin
      frame();
      pix(199, 279);
    end
    pix(220, 277);  chk("peak_hold_end", 24'hFFFFFF);
    frame();
    pix(220, 277);  chk("peak_198_above", 24'h000064);
    pix(220, 281);  chk("peak_198", 24'hFFFFFF);
    frame();
    pix(220, 280);  chk("peak_196_above", 24'h000064);
    pix(220, 283);  chk("peak_196", 24'hFFFFFF);
    pix(251, 283);  chk("peak_196_right", 24'hFFFFFF);

    wr(9, 700); frame();
    Mode = 1;
    pix(577, 200);  chk("grad_bar9", 24'hFF6400);
    pix(630, 200);  chk("gap_beyond", 24'h000031);
    pix(577, 480);  chk("y480_dark", 24'h000037);
    pix(577, 0);    chk("full_height", 24'hFF0000);
    pix(629, 479);  chk("bar9_corner", 24'hFFEF00);

    wr(12, 300); frame();
    pix(629, 479);  chk("addr12_ignored", 24'hFFEF00);
    pix(10, 300);   chk("addr12_bar0", 24'h00007E);

    pix(577, 200);
    @(negedge Clk);
    Reset_n = 0;
    @(negedge Clk);
    chk("midreset", 24'h000000);
    Reset_n = 1;
    pix(577, 200);  chk("post_reset_bg", 24'h000037);
    pix(10, 379);   chk("post_reset_pk0", 24'h00007E);
    frame();
    pix(577, 200);  chk("post_reset_swap", 24'h000037);
    pix(220, 283);  chk("post_reset_pk3", 24'h000064);

    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
